song_reader: RTL and testbench
==============================

SONG_READER -- requirements
Module: song_reader

Interface
REQ-001 Parameter BEAT_CYCLES, default 1000, clk cycles per duration unit; legal range 2..65535.
REQ-002 Parameter ADDR_W, default 6, song address width.
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 play  input  1  level; 1 = advance through song, 0 = pause/hold.
REQ-006 restart  input  1  single-cycle pulse; return to address 0 and idle.
REQ-007 rom_addr  output  ADDR_W  address to the synchronous song ROM.
REQ-008 rom_dout  input  16  ROM word, valid one cycle after rom_addr; [15] end-of-song, [14:9] note code, [8:0] duration in beats.
REQ-009 current_addr  output  ADDR_W  address of the note now sounding, consumed by the note display.
REQ-010 note  output  6  note code now sounding.
REQ-011 note_valid  output  1  note/current_addr describe a sounding note.
REQ-012 new_note  output  1  one-cycle pulse on the first cycle of each note.
REQ-013 song_done  output  1  end-of-song word reached.

Function
REQ-014 The block SHALL implement states IDLE, FETCH, DECODE, PLAY, DONE.
REQ-015 IDLE: hold; play=1 -> FETCH next cycle.
REQ-016 FETCH: rom_addr = fetch address; -> DECODE unconditionally.
REQ-017 DECODE: sample rom_dout; [15]=1 -> DONE; duration 0 -> fetch address +1, -> FETCH, no note issued; else load note, current_addr, beat count, duration count, -> PLAY.
REQ-018 new_note SHALL pulse and note_valid SHALL rise in the first PLAY cycle after a DECODE that loads a note.
REQ-019 PLAY: beat counter counts 0..BEAT_CYCLES-1 only while play=1; each wrap decrements remaining duration.
REQ-020 PLAY with play=0 SHALL freeze both counters; note, note_valid and current_addr SHALL hold.
REQ-021 A note SHALL occupy exactly duration*BEAT_CYCLES PLAY cycles with play=1, followed by FETCH, DECODE, then the next note's first PLAY cycle.
REQ-022 The final wrap of the final beat SHALL increment the fetch address and -> FETCH; note_valid stays 1 through FETCH/DECODE, holding the old note.
REQ-023 Fetch address SHALL increment modulo 2^ADDR_W; 63 -> 0 for ADDR_W=6.
REQ-024 play=0 in FETCH or DECODE SHALL NOT stall them; the pause takes effect in PLAY.
REQ-025 DONE: song_done=1, note_valid=0, new_note=0; hold until restart.
REQ-026 restart SHALL take priority in every state: next cycle IDLE, fetch/current address 0, note 0, note_valid 0, song_done 0, counters 0.
REQ-027 restart and play high together SHALL resolve to IDLE; FETCH begins the following cycle if play is still 1.
REQ-028 rom_addr SHALL equal the fetch address in all states.
REQ-029 All outputs SHALL be registered.

Reset
REQ-030 rst_n=0 SHALL immediately force IDLE, rom_addr=0, current_addr=0, note=0, note_valid=0, new_note=0, song_done=0, counters=0.
REQ-031 Reset mid-note SHALL discard the note; after rst_n release, playback restarts from address 0 only when play=1.

Verification (BEAT_CYCLES=4)
REQ-032 ROM[0]={0,note 5,dur 2}, ROM[1]={1,0,0}; play=1 at cycle 0 -> FETCH c1, DECODE c2, new_note c3 with note=5, current_addr=0; note_valid c3..c12; DECODE of ROM[1] c12; song_done=1 and note_valid=0 from c13.
REQ-033 As REQ-032 with play=0 for 3 cycles from c5 -> last note cycle shifts from c12 to c15; note=5 held throughout the pause.
REQ-034 ROM[0] dur 0, ROM[1] note 9 dur 1 -> addr 0 skipped, FETCH/DECODE of addr 1, new_note with note=9, current_addr=1, lasting 4 cycles.
REQ-035 Entries 0..63 all dur 1, none with [15] set -> after address 63, current_addr=0 with new_note; no song_done.
REQ-036 restart pulse in PLAY at address 7 -> next cycle IDLE, note_valid=0, current_addr=0; play held 1 -> FETCH of address 0 next.
REQ-037 rst_n low for 1 cycle mid-note -> all outputs 0 asynchronously; identical behaviour to REQ-032 after release.

Source files
------------

// File: rtl/song_reader_if.sv
// ---------------------------------------------------------------------------
// song_reader_if -- bus between the song reader and its synchronous song ROM.
//
// Signals
//   rom_addr  reader -> ROM   word address
//   rom_dout  ROM -> reader   16-bit song word
//
// Transfer contract (there is no valid/ready pair on this bus): the ROM
// always accepts rom_addr and returns the word for it on rom_dout exactly one
// clock cycle later. The reader never stalls the ROM and the ROM never
// stalls the reader, so the fixed one-cycle latency is the whole protocol.
//
// Modports
//   master  the song reader (drives rom_addr)
//   slave   the ROM         (drives rom_dout)
// ---------------------------------------------------------------------------
interface song_reader_if #(
    parameter int ADDR_W = 6
);
    logic [ADDR_W-1:0] rom_addr;
    logic [15:0]       rom_dout;

    modport master (output rom_addr, input  rom_dout);
    modport slave  (input  rom_addr, output rom_dout);
endinterface

// File: rtl/song_reader.sv
// ---------------------------------------------------------------------------
// song_reader -- walks a song stored in a synchronous ROM and presents the
// note currently sounding.
//
// Song word: [15] end-of-song, [14:9] note code, [8:0] duration in beats.
// One beat lasts BEAT_CYCLES clock cycles while play is high.
//
// Ports
//   clk           clock, all state changes on the rising edge
//   rst_n         asynchronous active-low reset
//   play          level: 1 advances through the song, 0 pauses inside a note
//   restart       one-cycle pulse: back to address 0 and idle
//   rom           ROM bus (master side): rom_addr out, rom_dout in
//   current_addr  address of the note now sounding
//   note          note code now sounding
//   note_valid    note/current_addr describe a sounding note
//   new_note      one-cycle pulse on the first cycle of each note
//   song_done     end-of-song word reached
//   state_dbg     current FSM state encoding, for observation only
//
// Every output comes straight from a register.
// ---------------------------------------------------------------------------
module song_reader #(
    parameter int BEAT_CYCLES = 1000,
    parameter int ADDR_W      = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              play,
    input  logic              restart,
    song_reader_if.master     rom,
    output logic [ADDR_W-1:0] current_addr,
    output logic [5:0]        note,
    output logic              note_valid,
    output logic              new_note,
    output logic              song_done,
    output logic [2:0]        state_dbg
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        PLAY   = 3'd3,
        DONE   = 3'd4
    } state_t;

    localparam logic [15:0] BEAT_LAST = 16'(BEAT_CYCLES - 1);

    state_t            state, state_n;
    logic [ADDR_W-1:0] fetch_addr, fetch_addr_n;
    logic [ADDR_W-1:0] cur_addr_n;
    logic [5:0]        note_n;
    logic              note_valid_n, new_note_n, song_done_n;
    logic [15:0]       beat_cnt, beat_n;
    logic [8:0]        dur_cnt, dur_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            fetch_addr   <= '0;
            current_addr <= '0;
            note         <= '0;
            note_valid   <= 1'b0;
            new_note     <= 1'b0;
            song_done    <= 1'b0;
            beat_cnt     <= '0;
            dur_cnt      <= '0;
        end else begin
            state        <= state_n;
            fetch_addr   <= fetch_addr_n;
            current_addr <= cur_addr_n;
            note         <= note_n;
            note_valid   <= note_valid_n;
            new_note     <= new_note_n;
            song_done    <= song_done_n;
            beat_cnt     <= beat_n;
            dur_cnt      <= dur_n;
        end
    end

    always_comb begin
        state_n      = state;
        fetch_addr_n = fetch_addr;
        cur_addr_n   = current_addr;
        note_n       = note;
        note_valid_n = note_valid;
        new_note_n   = 1'b0;
        song_done_n  = song_done;
        beat_n       = beat_cnt;
        dur_n        = dur_cnt;

        if (restart) begin
            state_n      = IDLE;
            fetch_addr_n = '0;
            cur_addr_n   = '0;
            note_n       = '0;
            note_valid_n = 1'b0;
            song_done_n  = 1'b0;
            beat_n       = '0;
            dur_n        = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (play) state_n = FETCH;
                end
                // FETCH and DECODE ignore play: a pause only bites in PLAY.
                FETCH: state_n = DECODE;
                DECODE: begin
                    if (rom.rom_dout[15]) begin
                        state_n      = DONE;
                        song_done_n  = 1'b1;
                        note_valid_n = 1'b0;
                    end else if (rom.rom_dout[8:0] == 9'd0) begin
                        // Zero-length entry: skip it without sounding anything.
                        fetch_addr_n = fetch_addr + 1'b1;
                        state_n      = FETCH;
                    end else begin
                        note_n       = rom.rom_dout[14:9];
                        cur_addr_n   = fetch_addr;
                        note_valid_n = 1'b1;
                        new_note_n   = 1'b1;
                        beat_n       = '0;
                        dur_n        = rom.rom_dout[8:0];
                        state_n      = PLAY;
                    end
                end
                PLAY: begin
                    if (play) begin
                        if (beat_cnt == BEAT_LAST) begin
                            beat_n = '0;
                            if (dur_cnt == 9'd1) begin
                                // Last beat done; the old note stays visible
                                // through the next FETCH/DECODE.
                                dur_n        = '0;
                                fetch_addr_n = fetch_addr + 1'b1;
                                state_n      = FETCH;
                            end else begin
                                dur_n = dur_cnt - 1'b1;
                            end
                        end else begin
                            beat_n = beat_cnt + 16'd1;
                        end
                    end
                end
                DONE: state_n = DONE;
                default: state_n = IDLE;
            endcase
        end
    end

    assign rom.rom_addr = fetch_addr;
    assign state_dbg    = state;

endmodule

// File: tb/tb_song_reader.sv
// ---------------------------------------------------------------------------
// tb_song_reader -- bench for song_reader with BEAT_CYCLES=4, ADDR_W=6.
// The expected output timeline of each scenario is derived from the song
// contents and the play/restart patterns by a note-level model, then every
// cycle of the DUT is compared against it, plus literal timing points.
// ---------------------------------------------------------------------------
module tb_song_reader;

    localparam int BEAT = 4;
    localparam int NMAX = 512;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       play = 1'b0;
    logic       restart = 1'b0;
    logic [5:0] current_addr;
    logic [5:0] note;
    logic       note_valid, new_note, song_done;
    logic [2:0] state_dbg;

    int checks = 0;
    int failures = 0;

    song_reader_if #(.ADDR_W(6)) rom_bus ();

    song_reader #(.BEAT_CYCLES(BEAT), .ADDR_W(6)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .play         (play),
        .restart      (restart),
        .rom          (rom_bus.master),
        .current_addr (current_addr),
        .note         (note),
        .note_valid   (note_valid),
        .new_note     (new_note),
        .song_done    (song_done),
        .state_dbg    (state_dbg)
    );

    // ---------------- clock / ROM ----------------
    always #5 clk = ~clk;

    logic [15:0] rom [0:63];
    always @(posedge clk) rom_bus.rom_dout <= rom[rom_bus.rom_addr];

    // ---------------- scenario data ----------------
    int   n_cyc;
    bit   pat_play [NMAX];
    bit   pat_rst  [NMAX];
    logic e_valid [NMAX], e_new [NMAX], e_done [NMAX];
    logic [5:0] e_note [NMAX], e_addr [NMAX];
    logic o_valid [NMAX], o_new [NMAX], o_done [NMAX];
    logic [5:0] o_note [NMAX], o_addr [NMAX];

    task automatic chk(input string tag, input int cyc, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic clear_pats();
        for (int k = 0; k < NMAX; k++) begin
            pat_play[k] = 1'b0;
            pat_rst[k]  = 1'b0;
        end
    endtask

    task automatic fill_from(input int c, input logic v, input logic [5:0] nt,
                             input logic [5:0] ad, input logic dn);
        for (int k = c; k < n_cyc; k++) begin
            e_valid[k] = v;
            e_note[k]  = nt;
            e_addr[k]  = ad;
            e_done[k]  = dn;
        end
    endtask

    // Note-level model: starting idle at cycle 'origin', each entry costs a
    // fetch and a decode cycle; a real note then lasts until dur*BEAT cycles
    // with play high have elapsed.
    task automatic build(input int origin);
        logic [5:0]  fa, cn, ca;
        logic [15:0] w;
        int c, f, d, need;
        fa = '0; cn = '0; ca = '0;
        fill_from(origin, 1'b0, 6'd0, 6'd0, 1'b0);
        for (int k = origin; k < n_cyc; k++) e_new[k] = 1'b0;
        c = origin;
        while (c < n_cyc && !pat_play[c]) c++;
        f = c + 1;
        while (f + 1 < n_cyc) begin
            d = f + 1;
            w = rom[fa];
            if (w[15]) begin
                fill_from(d + 1, 1'b0, cn, ca, 1'b1);
                break;
            end
            if (w[8:0] == 9'd0) begin
                fa = fa + 6'd1;
                f  = d + 1;
                continue;
            end
            cn = w[14:9];
            ca = fa;
            fill_from(d + 1, 1'b1, cn, ca, 1'b0);
            if (d + 1 < n_cyc) e_new[d + 1] = 1'b1;
            need = int'(w[8:0]) * BEAT;
            c = d + 1;
            while (need > 0 && c < n_cyc) begin
                if (pat_play[c]) need--;
                c++;
            end
            fa = fa + 6'd1;
            f  = c;
        end
    endtask

    task automatic build_all();
        build(0);
        for (int k = 0; k < n_cyc; k++)
            if (pat_rst[k] && k + 1 < n_cyc) build(k + 1);
    endtask

    // Cycle 0 is the cycle following the posedge at which this task starts.
    task automatic run_scn(input string tag);
        for (int k = 0; k < n_cyc; k++) begin
            @(negedge clk);
            o_valid[k] = note_valid;
            o_new[k]   = new_note;
            o_done[k]  = song_done;
            o_note[k]  = note;
            o_addr[k]  = current_addr;
            chk({tag, ".note_valid"}, k, 16'(note_valid), 16'(e_valid[k]));
            chk({tag, ".new_note"}, k, 16'(new_note), 16'(e_new[k]));
            chk({tag, ".song_done"}, k, 16'(song_done), 16'(e_done[k]));
            chk({tag, ".note"}, k, 16'(note), 16'(e_note[k]));
            chk({tag, ".current_addr"}, k, 16'(current_addr), 16'(e_addr[k]));
            play    = pat_play[k];
            restart = pat_rst[k];
        end
        @(negedge clk);
        play    = 1'b0;
        restart = 1'b0;
    endtask

    // Asynchronous reset: outputs are checked 1 time unit after rst_n falls.
    task automatic do_reset(input string tag);
        #2;
        rst_n   = 1'b0;
        play    = 1'b0;
        restart = 1'b0;
        #1;
        chk({tag, ".note_valid"}, 0, 16'(note_valid), 16'd0);
        chk({tag, ".new_note"}, 0, 16'(new_note), 16'd0);
        chk({tag, ".song_done"}, 0, 16'(song_done), 16'd0);
        chk({tag, ".note"}, 0, 16'(note), 16'd0);
        chk({tag, ".current_addr"}, 0, 16'(current_addr), 16'd0);
        chk({tag, ".rom_addr"}, 0, 16'(rom_bus.rom_addr), 16'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
    endtask

    task automatic rom_basic();
        for (int i = 0; i < 64; i++) rom[i] = 16'h0000;
        rom[0] = {1'b0, 6'd5, 9'd2};
        rom[1] = 16'h8000;
    endtask

    task automatic basic_literals(input string tag);
        chk({tag, ".new_c3"}, 3, 16'(o_new[3]), 16'd1);
        chk({tag, ".note_c3"}, 3, 16'(o_note[3]), 16'd5);
        chk({tag, ".addr_c3"}, 3, 16'(o_addr[3]), 16'd0);
        chk({tag, ".valid_c2"}, 2, 16'(o_valid[2]), 16'd0);
        chk({tag, ".valid_c12"}, 12, 16'(o_valid[12]), 16'd1);
        chk({tag, ".valid_c13"}, 13, 16'(o_valid[13]), 16'd0);
        chk({tag, ".done_c12"}, 12, 16'(o_done[12]), 16'd0);
        chk({tag, ".done_c13"}, 13, 16'(o_done[13]), 16'd1);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) rom[i] = 16'h0000;
        do_reset("reset");

        // Single note of 2 beats, then end of song.
        rom_basic();
        clear_pats();
        n_cyc = 20;
        for (int k = 0; k < n_cyc; k++) pat_play[k] = 1'b1;
        build_all();
        run_scn("basic");
        basic_literals("basic");

        // Pause of three cycles starting at cycle 5.
        do_reset("reset_pause");
        for (int k = 5; k < 8; k++) pat_play[k] = 1'b0;
        build_all();
        run_scn("pause");
        chk("pause.note_c6", 6, 16'(o_note[6]), 16'd5);
        chk("pause.valid_c6", 6, 16'(o_valid[6]), 16'd1);
        chk("pause.valid_c15", 15, 16'(o_valid[15]), 16'd1);
        chk("pause.valid_c16", 16, 16'(o_valid[16]), 16'd0);
        chk("pause.done_c16", 16, 16'(o_done[16]), 16'd1);

        // Zero-duration entry is skipped.
        do_reset("reset_skip");
        rom[0] = {1'b0, 6'd3, 9'd0};
        rom[1] = {1'b0, 6'd9, 9'd1};
        rom[2] = 16'h8000;
        clear_pats();
        for (int k = 0; k < n_cyc; k++) pat_play[k] = 1'b1;
        build_all();
        run_scn("skip");
        chk("skip.valid_c4", 4, 16'(o_valid[4]), 16'd0);
        chk("skip.new_c5", 5, 16'(o_new[5]), 16'd1);
        chk("skip.note_c5", 5, 16'(o_note[5]), 16'd9);
        chk("skip.addr_c5", 5, 16'(o_addr[5]), 16'd1);
        chk("skip.valid_c10", 10, 16'(o_valid[10]), 16'd1);
        chk("skip.done_c11", 11, 16'(o_done[11]), 16'd1);

        // Every entry one beat long, no end marker: address wraps 63 -> 0.
        do_reset("reset_wrap");
        for (int i = 0; i < 64; i++) rom[i] = {1'b0, 6'(i), 9'd1};
        clear_pats();
        n_cyc = 400;
        for (int k = 0; k < n_cyc; k++) pat_play[k] = 1'b1;
        build_all();
        run_scn("wrap");
        chk("wrap.addr_c381", 381, 16'(o_addr[381]), 16'd63);
        chk("wrap.new_c387", 387, 16'(o_new[387]), 16'd1);
        chk("wrap.addr_c387", 387, 16'(o_addr[387]), 16'd0);
        chk("wrap.done_c399", 399, 16'(o_done[399]), 16'd0);

        // Restart while address 7 is playing.
        do_reset("reset_restart");
        n_cyc = 60;
        clear_pats();
        for (int k = 0; k < n_cyc; k++) pat_play[k] = 1'b1;
        pat_rst[47] = 1'b1;
        build_all();
        run_scn("restart");
        chk("restart.addr_c47", 47, 16'(o_addr[47]), 16'd7);
        chk("restart.valid_c48", 48, 16'(o_valid[48]), 16'd0);
        chk("restart.addr_c48", 48, 16'(o_addr[48]), 16'd0);
        chk("restart.new_c51", 51, 16'(o_new[51]), 16'd1);
        chk("restart.addr_c51", 51, 16'(o_addr[51]), 16'd0);

        // Reset in the middle of a note, then the basic song again.
        do_reset("reset_pre_mid");
        rom_basic();
        clear_pats();
        n_cyc = 7;
        for (int k = 0; k < n_cyc; k++) pat_play[k] = 1'b1;
        build_all();
        run_scn("pre_mid");
        do_reset("reset_mid_note");
        n_cyc = 20;
        for (int k = 0; k < n_cyc; k++) pat_play[k] = 1'b1;
        build_all();
        run_scn("after_rst");
        basic_literals("after_rst");

        // Random songs with random pauses; one run also restarts.
        for (int r = 0; r < 4; r++) begin
            do_reset("reset_rand");
            for (int i = 0; i < 64; i++)
                rom[i] = {1'b0, 6'($urandom_range(0, 63)), 9'($urandom_range(0, 3))};
            rom[$urandom_range(6, 16)][15] = 1'b1;
            clear_pats();
            n_cyc = 400;
            for (int k = 0; k < n_cyc; k++) pat_play[k] = ($urandom_range(0, 3) != 0);
            if (r == 3) pat_rst[$urandom_range(20, 150)] = 1'b1;
            build_all();
            run_scn($sformatf("rand%0d", r));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
